// File: rtl/io_responder_pkg.sv
// Shared types, widths and IO address map for the memory-mapped IO responder.
package io_responder_pkg;

  localparam int unsigned CYCLE_WIDTH     = 32;
  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned DATA_ADDR_WIDTH = 16;
  localparam int unsigned LAMP_WIDTH      = 8;
  localparam int unsigned IO_ADDR_WIDTH   = 7;
  localparam int unsigned OLED_ADDR_WIDTH = 6;
  localparam int unsigned OLED_DATA_WIDTH = 8;
  localparam int unsigned IO_ADDR_BIT_POS = 15;
  localparam int unsigned BTN_SYNC_STAGES = 2;

  typedef logic [CYCLE_WIDTH-1:0]     CyclePath;
  typedef logic [LAMP_WIDTH-1:0]      LampPath;
  typedef logic [DATA_WIDTH-1:0]      DataPath;
  typedef logic [DATA_ADDR_WIDTH-1:0] DataAddrPath;
  typedef logic [IO_ADDR_WIDTH-1:0]   IoAddrPath;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } IoCycleState;

  // Word index within IO space (byte address bits 8:2)
  localparam IoAddrPath IO_ADDR_SORT_FINISH = 7'h00;
  localparam IoAddrPath IO_ADDR_SORT_COUNT  = 7'h01;
  localparam IoAddrPath IO_ADDR_LAMP        = 7'h02;
  localparam IoAddrPath IO_ADDR_LED_CTRL    = 7'h03;
  localparam IoAddrPath IO_ADDR_OLED_READY  = 7'h08;
  localparam IoAddrPath IO_ADDR_OLED_UPDATE = 7'h09;
  localparam IoAddrPath IO_ADDR_OLED_CLEAR  = 7'h0A;
  localparam IoAddrPath IO_ADDR_SORT_START  = 7'h10;
  localparam IoAddrPath IO_ADDR_BTNU        = 7'h11;
  localparam IoAddrPath IO_ADDR_CP          = 7'h12;
  localparam IoAddrPath IO_ADDR_CH          = 7'h13;
  localparam IoAddrPath IO_ADDR_CYCLE       = 7'h14;

  function automatic IoAddrPath PICK_IO_ADDR(input DataAddrPath addr);
    return addr[8:2];
  endfunction

endpackage

// File: rtl/io_responder_btn_sync.sv
// Multi-flop synchroniser for one raw button, with a rising-edge pulse on the synced value.
module io_responder_btn_sync
  import io_responder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = BTN_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_sync,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_stages;
  logic                   r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stages <= '0;
      r_prev   <= 1'b0;
    end else begin
      r_stages <= {r_stages[SYNC_STAGES-2:0], i_btn};
      r_prev   <= r_stages[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_stages[SYNC_STAGES-1];
  assign o_rise = r_stages[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/io_responder.sv
// IO target for CPU accesses with bit 15 set: sort control and cycle counter, lamps,
// LED control, button synchronisers and the ready-gated OLED request handshake.
module io_responder
  import io_responder_pkg::*;
#(
  parameter int unsigned CYCLE_W     = CYCLE_WIDTH,
  parameter int unsigned SYNC_STAGES = BTN_SYNC_STAGES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  DataAddrPath                dataAddr,
  input  logic                       dataWE,
  input  DataPath                    wrData,
  output DataPath                    rdData,
  output logic                       ioSel,
  input  logic                       btnStart,
  input  logic                       btnU,
  input  logic                       btnCP,
  input  logic                       btnCH,
  input  logic                       oledReady,
  output logic                       oledUpdate,
  output logic                       oledClear,
  output logic                       oledWE,
  output logic [OLED_ADDR_WIDTH-1:0] oledAddr,
  output logic [OLED_DATA_WIDTH-1:0] oledData,
  output logic [CYCLE_W-1:0]         sortCount,
  output logic [CYCLE_W-1:0]         cycleCount,
  output LampPath                    lamp,
  output logic                       ledCtrl,
  output logic                       sortFinished
);

  IoCycleState                r_state;
  logic [CYCLE_W-1:0]         r_cycle;
  logic [CYCLE_W-1:0]         r_sort_count;
  logic                       r_finished;
  LampPath                    r_lamp;
  logic                       r_led_ctrl;
  logic                       r_upd_pend;
  logic                       r_clr_pend;
  logic                       r_oled_update;
  logic                       r_oled_clear;
  logic                       r_oled_we;
  logic [OLED_ADDR_WIDTH-1:0] r_oled_addr;
  logic [OLED_DATA_WIDTH-1:0] r_oled_data;

  IoAddrPath w_io_addr;
  logic      w_io_wr;
  logic      w_wr_finish;
  logic      w_wr_upd;
  logic      w_wr_clr;
  logic      w_wr_char;
  logic      w_issue_clr;
  logic      w_issue_upd;
  logic      w_start_sync, w_start_edge;
  logic      w_u_sync, w_u_rise;
  logic      w_cp_sync, w_cp_rise;
  logic      w_ch_sync, w_ch_rise;
  logic      w_unused;

  io_responder_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
    .clk(clk), .rst(rst), .i_btn(btnStart), .o_sync(w_start_sync), .o_rise(w_start_edge));
  io_responder_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_u (
    .clk(clk), .rst(rst), .i_btn(btnU), .o_sync(w_u_sync), .o_rise(w_u_rise));
  io_responder_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cp (
    .clk(clk), .rst(rst), .i_btn(btnCP), .o_sync(w_cp_sync), .o_rise(w_cp_rise));
  io_responder_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ch (
    .clk(clk), .rst(rst), .i_btn(btnCH), .o_sync(w_ch_sync), .o_rise(w_ch_rise));

  // Bits 14:9 are not decoded, so the IO window aliases across the upper half
  assign w_io_addr   = PICK_IO_ADDR(dataAddr);
  assign ioSel       = dataAddr[IO_ADDR_BIT_POS];
  assign w_io_wr     = dataWE & ioSel;
  assign w_wr_finish = w_io_wr & (w_io_addr == IO_ADDR_SORT_FINISH);
  assign w_wr_upd    = w_io_wr & (w_io_addr == IO_ADDR_OLED_UPDATE);
  assign w_wr_clr    = w_io_wr & (w_io_addr == IO_ADDR_OLED_CLEAR);
  assign w_wr_char   = w_io_wr & w_io_addr[IO_ADDR_WIDTH-1];
  assign w_unused    = ^{dataAddr[14:9], dataAddr[1:0], w_u_rise, w_cp_rise, w_ch_rise};

  // Clear has priority; update waits for the next ready cycle
  assign w_issue_clr = r_clr_pend & oledReady;
  assign w_issue_upd = r_upd_pend & oledReady & ~r_clr_pend;

  // Cycle FSM: a finish write in RUN beats a coincident start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cycle    <= '0;
      r_finished <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_wr_finish) begin
            r_state    <= DONE;
            r_finished <= 1'b1;
          end else begin
            r_cycle <= r_cycle + CYCLE_W'(1);
          end
        end
        default: begin
          if (w_start_edge) begin
            r_state    <= RUN;
            r_cycle    <= '0;
            r_finished <= 1'b0;
          end else if (w_wr_finish) begin
            r_finished <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sort_count <= '0;
      r_lamp       <= '0;
      r_led_ctrl   <= 1'b0;
    end else if (w_io_wr) begin
      if (w_io_addr == IO_ADDR_SORT_COUNT) r_sort_count <= CYCLE_W'(wrData);
      if (w_io_addr == IO_ADDR_LAMP)       r_lamp       <= wrData[LAMP_WIDTH-1:0];
      if (w_io_addr == IO_ADDR_LED_CTRL)   r_led_ctrl   <= wrData[0];
    end
  end

  // OLED requests and character strobe; a write to a pending flag is absorbed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upd_pend    <= 1'b0;
      r_clr_pend    <= 1'b0;
      r_oled_update <= 1'b0;
      r_oled_clear  <= 1'b0;
      r_oled_we     <= 1'b0;
      r_oled_addr   <= '0;
      r_oled_data   <= '0;
    end else begin
      r_oled_clear  <= w_issue_clr;
      r_oled_update <= w_issue_upd;
      r_clr_pend    <= w_issue_clr ? 1'b0 : (r_clr_pend | w_wr_clr);
      r_upd_pend    <= w_issue_upd ? 1'b0 : (r_upd_pend | w_wr_upd);
      r_oled_we     <= w_wr_char;
      if (w_wr_char) begin
        r_oled_addr <= w_io_addr[OLED_ADDR_WIDTH-1:0];
        r_oled_data <= wrData[OLED_DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    rdData = '0;
    if (ioSel) begin
      case (w_io_addr)
        IO_ADDR_SORT_COUNT: rdData = DATA_WIDTH'(r_sort_count);
        IO_ADDR_LAMP:       rdData = DATA_WIDTH'(r_lamp);
        IO_ADDR_LED_CTRL:   rdData = DATA_WIDTH'(r_led_ctrl);
        IO_ADDR_OLED_READY: rdData = DATA_WIDTH'(oledReady);
        IO_ADDR_SORT_START: rdData = DATA_WIDTH'(w_start_sync);
        IO_ADDR_BTNU:       rdData = DATA_WIDTH'(w_u_sync);
        IO_ADDR_CP:         rdData = DATA_WIDTH'(w_cp_sync);
        IO_ADDR_CH:         rdData = DATA_WIDTH'(w_ch_sync);
        IO_ADDR_CYCLE:      rdData = DATA_WIDTH'(r_cycle);
        default:            rdData = '0;
      endcase
    end
  end

  assign sortCount    = r_sort_count;
  assign cycleCount   = r_cycle;
  assign sortFinished = r_finished;
  assign lamp         = r_lamp;
  assign ledCtrl      = r_led_ctrl;
  assign oledUpdate   = r_oled_update;
  assign oledClear    = r_oled_clear;
  assign oledWE       = r_oled_we;
  assign oledAddr     = r_oled_addr;
  assign oledData     = r_oled_data;

endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Memory-mapped IO target for the single-cycle CPU; answers every data access with address bit 15 set (IO space starting at $8000).
- Owns the sort-control registers, cycle counter, lamp and LED-control registers, and the button synchronisers.
- Hands OLED character writes and update/clear requests to the OLED driver over a ready-gated handshake.
- Sits between the CPU data port and the board IO (buttons, lamps, OLED driver, dynamic display).

Parameters:
- CYCLE_W, 32, width of the cycle counter and sort-count register (equals package CYCLE_WIDTH).
- SYNC_STAGES, 2, flip-flop depth of each button synchroniser (must be 2 or more).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- dataAddr  in  16  CPU data byte address (DataAddrPath).
- dataWE  in  1  CPU store strobe.
- wrData  in  32  CPU store data (DataPath).
- rdData  out  32  IO read data; combinational from registered state.
- ioSel  out  1  dataAddr[15]; tells the data-memory mux to take rdData.
- btnStart, btnU, btnCP, btnCH  in  1 each  raw asynchronous buttons.
- oledReady  in  1  OLED driver idle.
- oledUpdate, oledClear  out  1 each  one-cycle request pulses.
- oledWE  out  1  character-write strobe.
- oledAddr  out  6  character index.
- oledData  out  8  ASCII code.
- sortCount  out  CYCLE_W  last value stored to SORT_COUNT.
- cycleCount  out  CYCLE_W  cycle counter.
- lamp  out  8  lamp register (LampPath).
- ledCtrl  out  1  0 = show sort result, 1 = user display.
- sortFinished  out  1  finish flag.

Behaviour:
- Decode: ioAddr = dataAddr[8:2]. Bits 14:9 are ignored, so IO space aliases.
- Write commit: a write takes effect on the clk edge where dataWE=1 and dataAddr[15]=1.
- Reset values: every register and output is 0, and the FSM is IDLE.
- Button sync: each button passes through SYNC_STAGES flops.
- Start edge: startEdge = synced start AND NOT its previous synced value.

Cycle FSM (states IDLE, RUN, DONE):
- IDLE → RUN on startEdge; cycleCount and sortFinished are cleared.
- RUN: cycleCount increments by 1 each clk and wraps from 2^CYCLE_W-1 to 0 with no flag.
- RUN → DONE on a write to SORT_FINISH ($8000); sortFinished is set and cycleCount freezes.
- Write to SORT_FINISH in the same cycle as startEdge while in RUN: the write wins and the edge is dropped.
- DONE → RUN on startEdge; cycleCount is cleared to 0 in that cycle and sortFinished is cleared.
- Write to SORT_FINISH in IDLE or DONE sets sortFinished only; the state is unchanged.
- Reset mid-RUN: immediate return to IDLE with all registers zeroed.

Registers and read data:
- SORT_COUNT $8004 loads wrData.
- LAMP $8008 loads wrData[7:0].
- LED_CTRL $800C loads wrData[0].
- Reads return the register value, zero-extended.

Read-only locations (rdData bit 0, all other bits 0):
- SORT_START $8040: synced start.
- BTNU $8044: synced btnU.
- CP $8048: synced btnCP.
- CH $804C: synced btnCH.

Other reads and unmapped IO:
- CYCLE $8050 returns cycleCount.
- Any other IO address, including $8060–$80BC, reads 0 and ignores writes.
- When dataAddr[15]=0, rdData=0.

OLED:
- OLED_READY $8020 reads oledReady.
- A write to $8024 sets updPend; a write to $8028 sets clrPend.
- A pending flag is issued as a one-cycle pulse in the first cycle with oledReady=1, then cleared.
- If both flags are pending, clear goes first and update follows at the next ready.
- A write to an already-pending flag is absorbed (no second pulse).
- Writes to $8100–$81FC drive oledWE=1 one cycle later, with oledAddr=ioAddr[5:0] and oledData=wrData[7:0].
- oledWE is not gated by ready; the driver buffers characters.

Decomposition:
- Shared package:
  - IO_ADDR_* constants, PICK_IO_ADDR, IO_ADDR_BIT_POS.
  - CyclePath, LampPath, DataPath, DataAddrPath.
  - New typedef IoCycleState (IDLE/RUN/DONE) and constant BTN_SYNC_STAGES.
- One sub-module, btn_sync: SYNC_STAGES-deep synchroniser plus rising-edge output, instantiated four times.

Test Plan:
- Reset: assert rst mid-RUN with cycleCount=100 → all outputs 0 and state IDLE the same instant; rdData at $8050 reads 0.
- Cycle count: btnStart pulse, then 50 clk, then store to $8000 → sortFinished=1, cycleCount frozen at 50±sync latency (exact value checked against model), read $8050 equals it; a second start clears it to 0.
- Registers: store 0x1234_5678 to $8004, 0x1FF to $8008, 3 to $800C → sortCount=0x12345678, lamp=0xFF, ledCtrl=1; reads return the same; alias $C004 also hits SORT_COUNT.
- OLED handshake: oledReady=0, store to $8024 and $8028 → no pulses; raise ready → oledClear pulse, then oledUpdate pulse on the next ready cycle; each exactly 1 cycle.
- OLED characters: store 0x41 to $81FC → next cycle oledWE=1, oledAddr=63, oledData=0x41; store to $807C → no oledWE.
- Wrap and collision: preload cycleCount near 2^32-1 by forcing, run 3 clk → wraps to 1; finish write coincident with startEdge in RUN → DONE with sortFinished=1.
